// File: rtl/fb_sram_ctrl_if.sv
// fb_sram_ctrl_if: CPU write channel and VGA pixel-fetch channel of the
// framebuffer SRAM controller.
//   master : CPU/VGA side (drives wr_valid/addr/data, rd_req/rd_addr)
//   slave  : controller side (drives wr_ready, rd_valid, rd_data)
interface fb_sram_ctrl_if #(
    parameter int AW = 17
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [7:0]    rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/fb_sram_ctrl.sv
// fb_sram_ctrl: arbitrates the single port of an external 8-bit async SRAM
// between queued CPU byte writes and VGA pixel fetches. Fetches always win;
// writes drain from a small FIFO in the free cycles.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   bus (slave)     : write channel (valid/ready) and fetch channel (req/valid)
//   fifo_count      : current write FIFO occupancy
//   sram_a          : SRAM address
//   sram_dq_out/oe  : write data and drive enable for the top-level tristate
//   sram_dq_in      : data read back from the SRAM pins
//   sram_n_we/n_oe  : active-low write strobe / output enable (registered)
module fb_sram_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    fb_sram_ctrl_if.slave          bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [AW-1:0]          sram_a,
    output logic [7:0]             sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [7:0]             sram_dq_in,
    output logic                   sram_n_we,
    output logic                   sram_n_oe
);
    localparam int             PW   = $clog2(DEPTH);
    localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_entry_t;

    typedef enum logic [1:0] {IDLE, READ, WRITE, WR_HOLD} state_t;

    state_t        state;
    wr_entry_t     mem [DEPTH];
    wr_entry_t     head;
    logic [PW-1:0] wptr, rptr;
    logic          rd_pend;
    logic [AW-1:0] rd_addr_q;
    logic [7:0]    wd_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          push, pop, go_read;

    assign bus.wr_ready = (fifo_count != FULL);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign sram_dq_out  = wd_q;

    assign head    = mem[rptr];
    assign push    = bus.wr_valid && bus.wr_ready;
    // A fetch seen in IDLE (latched or arriving this cycle) beats any write.
    assign go_read = (state == IDLE) && (rd_pend || bus.rd_req);
    assign pop     = (state == IDLE) && !go_read && (fifo_count != '0);

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Fetch latch: holds a strobe that arrives while the port is busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            if (go_read)         rd_pend <= 1'b0;
            else if (bus.rd_req) rd_pend <= 1'b1;
            if (bus.rd_req) rd_addr_q <= bus.rd_addr;
        end
    end

    // SRAM sequencer. Pin values are loaded on the transition into each
    // state so every control output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sram_a     <= '0;
            wd_q       <= '0;
            sram_dq_oe <= 1'b0;
            sram_n_we  <= 1'b1;
            sram_n_oe  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_read) begin
                        state      <= READ;
                        // a same-cycle strobe has not reached rd_addr_q yet
                        sram_a     <= bus.rd_req ? bus.rd_addr : rd_addr_q;
                        sram_n_oe  <= 1'b0;
                        sram_dq_oe <= 1'b0;
                    end else if (pop) begin
                        state      <= WRITE;
                        sram_a     <= head.addr;
                        wd_q       <= head.data;
                        sram_dq_oe <= 1'b1;
                        sram_n_oe  <= 1'b1;
                        sram_n_we  <= 1'b0;
                    end else begin
                        sram_a <= rd_addr_q;
                    end
                end
                READ: begin
                    rd_data_q  <= sram_dq_in;
                    rd_valid_q <= 1'b1;
                    sram_a     <= rd_addr_q;
                    state      <= IDLE;
                end
                WRITE: begin
                    // strobe rises while address/data stay put (hold time)
                    sram_n_we <= 1'b1;
                    state     <= WR_HOLD;
                end
                WR_HOLD: begin
                    sram_dq_oe <= 1'b0;
                    sram_n_oe  <= 1'b0;
                    sram_a     <= rd_addr_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_sram_ctrl.sv
module tb_fb_sram_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    fifo_count;
    logic [AW-1:0] sram_a;
    logic [7:0]    sram_dq_out;
    logic          sram_dq_oe;
    logic [7:0]    sram_dq_in;
    logic          sram_n_we;
    logic          sram_n_oe;

    int n_cmp = 0;
    int n_err = 0;

    fb_sram_ctrl_if #(.AW(AW)) bus ();

    fb_sram_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .fifo_count(fifo_count),
        .sram_a(sram_a), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_n_we(sram_n_we), .sram_n_oe(sram_n_oe)
    );

    always #5 clk = ~clk;

    // Async SRAM model: byte latched on the rising edge of the write strobe.
    logic [7:0]    sram_mem [0:(1<<AW)-1];
    int            wcount = 0;
    logic [AW-1:0] wlog_a [$];
    logic [7:0]    wlog_d [$];

    assign sram_dq_in = sram_n_oe ? 8'hFF : sram_mem[sram_a];

    always @(posedge sram_n_we) begin
        if (sram_dq_oe === 1'b1 && reset === 1'b0) begin
            sram_mem[sram_a] = sram_dq_out;
            wlog_a.push_back(sram_a);
            wlog_d.push_back(sram_dq_out);
            wcount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        tick(); tick();
        n_cmp++; if (sram_n_we !== 1'b1)   begin n_err++; $display("FAIL rst_n_we got %b want 1", sram_n_we); end
        n_cmp++; if (sram_n_oe !== 1'b0)   begin n_err++; $display("FAIL rst_n_oe got %b want 0", sram_n_oe); end
        n_cmp++; if (sram_dq_oe !== 1'b0)  begin n_err++; $display("FAIL rst_dq_oe got %b want 0", sram_dq_oe); end
        n_cmp++; if (sram_a !== 17'h0)     begin n_err++; $display("FAIL rst_a got %h want 0", sram_a); end
        n_cmp++; if (sram_dq_out !== 8'h0) begin n_err++; $display("FAIL rst_dq_out got %h want 0", sram_dq_out); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 8'h0) begin n_err++; $display("FAIL rst_rd_data got %h want 0", bus.rd_data); end
        n_cmp++; if (fifo_count !== 4'd0)  begin n_err++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready got %b want 1", bus.wr_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        sram_mem[17'h00140] = 8'hE3;
        bus.rd_addr = 17'h00140; bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rd1_early_valid got %b want 0", bus.rd_valid); end
        n_cmp++; if (sram_a !== 17'h00140 || sram_n_oe !== 1'b0) begin n_err++; $display("FAIL rd1_pins got a=%h oe=%b want a=00140 oe=0", sram_a, sram_n_oe); end
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL rd1_valid got %b want 1", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 8'hE3) begin n_err++; $display("FAIL rd1_data got %h want e3", bus.rd_data); end
        n_cmp++; if (sram_n_we !== 1'b1)    begin n_err++; $display("FAIL rd1_n_we got %b want 1", sram_n_we); end
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hE3) begin n_err++; $display("FAIL rd1_pulse got v=%b d=%h want v=0 d=e3", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_single_write();
        bus.wr_addr = 17'h10005; bus.wr_data = 8'h1C; bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL wr1_count got %0d want 1", fifo_count); end
        n_cmp++; if (sram_n_we !== 1'b1)  begin n_err++; $display("FAIL wr1_pop_delay got n_we=%b want 1", sram_n_we); end
        tick(); // WRITE
        n_cmp++; if (sram_n_we !== 1'b0 || sram_dq_oe !== 1'b1 || sram_n_oe !== 1'b1) begin n_err++; $display("FAIL wr1_write_ctl got we=%b dqoe=%b oe=%b want 0 1 1", sram_n_we, sram_dq_oe, sram_n_oe); end
        n_cmp++; if (sram_a !== 17'h10005 || sram_dq_out !== 8'h1C) begin n_err++; $display("FAIL wr1_write_bus got a=%h d=%h want 10005 1c", sram_a, sram_dq_out); end
        tick(); // WR_HOLD
        n_cmp++; if (sram_n_we !== 1'b1 || sram_dq_oe !== 1'b1 || sram_a !== 17'h10005 || sram_dq_out !== 8'h1C) begin n_err++; $display("FAIL wr1_hold got we=%b dqoe=%b a=%h d=%h want 1 1 10005 1c", sram_n_we, sram_dq_oe, sram_a, sram_dq_out); end
        tick(); // IDLE
        n_cmp++; if (sram_dq_oe !== 1'b0 || sram_n_oe !== 1'b0 || sram_n_we !== 1'b1) begin n_err++; $display("FAIL wr1_idle got dqoe=%b oe=%b we=%b want 0 0 1", sram_dq_oe, sram_n_oe, sram_n_we); end
        n_cmp++; if (sram_mem[17'h10005] !== 8'h1C) begin n_err++; $display("FAIL wr1_mem got %h want 1c", sram_mem[17'h10005]); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL wr1_count_end got %0d want 0", fifo_count); end
    endtask

    // Pushes at 1/cycle outrun the 1-per-3-cycle drain, so the FIFO must fill.
    task automatic test_fill();
        int base = wcount;
        int idx  = 0;
        int cyc  = 0;
        bit saw_full = 0;
        bit acc;
        while (idx < 14 && cyc < 200) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 17'h00400 + 17'(idx);
            bus.wr_data  = 8'hA0 + 8'(idx);
            #1;
            n_cmp++; if (bus.wr_ready !== (fifo_count != 4'd8)) begin n_err++; $display("FAIL fill_ready got %b want %b at count %0d", bus.wr_ready, (fifo_count != 4'd8), fifo_count); end
            if (fifo_count == 4'd8) saw_full = 1;
            acc = bus.wr_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        n_cmp++; if (idx != 14) begin n_err++; $display("FAIL fill_pushes got %0d want 14", idx); end
        n_cmp++; if (!saw_full) begin n_err++; $display("FAIL fill_full got 0 want 1"); end
        cyc = 0;
        while (wcount - base < 14 && cyc < 100) begin tick(); cyc++; end
        n_cmp++; if (wcount - base != 14) begin n_err++; $display("FAIL fill_drain got %0d want 14", wcount - base); end
        for (int i = 0; i < 14; i++) begin
            if (base + i < wlog_a.size()) begin
                n_cmp++; if (wlog_a[base+i] !== 17'h00400 + 17'(i) || wlog_d[base+i] !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL fill_order[%0d] got %h/%h want %h/%h", i, wlog_a[base+i], wlog_d[base+i], 17'h00400 + 17'(i), 8'hA0 + 8'(i)); end
            end
        end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL fill_count_end got %0d want 0", fifo_count); end
    endtask

    task automatic test_collision();
        int base = wcount;
        int cyc  = 0;
        int lat;
        sram_mem[17'h00600] = 8'h77;
        bus.wr_valid = 1'b1; bus.wr_addr = 17'h00500; bus.wr_data = 8'h11;
        tick();
        bus.wr_addr = 17'h00501; bus.wr_data = 8'h22;
        tick();
        bus.wr_valid = 1'b0;
        while (sram_n_we !== 1'b0 && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (sram_n_we !== 1'b0) begin n_err++; $display("FAIL col_write_start got n_we=%b want 0", sram_n_we); end
        bus.rd_addr = 17'h00600; bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        lat = 1;
        while (bus.rd_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL col_latency got %0d want 4", lat); end
        n_cmp++; if (bus.rd_data !== 8'h77) begin n_err++; $display("FAIL col_data got %h want 77", bus.rd_data); end
        n_cmp++; if (wcount - base < 1 || sram_mem[17'h00500] !== 8'h11) begin n_err++; $display("FAIL col_write_done got %h want 11", sram_mem[17'h00500]); end
        cyc = 0;
        while (wcount - base < 2 && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (sram_mem[17'h00501] !== 8'h22 || wcount - base != 2) begin n_err++; $display("FAIL col_second got %h n=%0d want 22 n=2", sram_mem[17'h00501], wcount - base); end
    endtask

    // Fetch every 4 cycles while 6 writes are queued: every fetch returns
    // within 4 cycles and the writes still drain.
    task automatic test_back_to_back();
        int base = wcount;
        int idx  = 0;
        int nreq = 0;
        int nval = 0;
        int req_cyc [$];
        bit acc;
        for (int k = 0; k < 10; k++) sram_mem[17'h00800 + 17'(k)] = 8'hC0 + 8'(k);
        for (int c = 0; c < 60; c++) begin
            bus.rd_req  = (c % 4 == 0) && (c < 40);
            bus.rd_addr = 17'h00800 + 17'(nreq);
            bus.wr_valid = (idx < 6);
            bus.wr_addr  = 17'h00700 + 17'(idx);
            bus.wr_data  = 8'h30 + 8'(idx);
            #1;
            acc = bus.wr_valid && bus.wr_ready;
            if (bus.rd_req) begin req_cyc.push_back(c); nreq++; end
            tick();
            if (acc) idx++;
            bus.rd_req = 1'b0;
            if (bus.rd_valid === 1'b1) begin
                n_cmp++; if (bus.rd_data !== 8'hC0 + 8'(nval)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", nval, bus.rd_data, 8'hC0 + 8'(nval)); end
                if (nval < req_cyc.size()) begin
                    n_cmp++; if (c - req_cyc[nval] + 1 > 4) begin n_err++; $display("FAIL b2b_latency[%0d] got %0d want <=4", nval, c - req_cyc[nval] + 1); end
                end
                nval++;
            end
        end
        bus.wr_valid = 1'b0;
        n_cmp++; if (nval != 10) begin n_err++; $display("FAIL b2b_valids got %0d want 10", nval); end
        n_cmp++; if (wcount - base != 6) begin n_err++; $display("FAIL b2b_drain got %0d want 6", wcount - base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (sram_mem[17'h00700 + 17'(i)] !== 8'h30 + 8'(i)) begin n_err++; $display("FAIL b2b_mem[%0d] got %h want %h", i, sram_mem[17'h00700 + 17'(i)], 8'h30 + 8'(i)); end
        end
    endtask

    task automatic test_read_after_write();
        int cyc = 0;
        bus.wr_valid = 1'b1; bus.wr_addr = 17'h00200; bus.wr_data = 8'h55;
        tick();
        bus.wr_valid = 1'b0;
        while ((fifo_count !== 4'd0 || sram_dq_oe !== 1'b0) && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (fifo_count !== 4'd0 || sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL raw_drain got count=%0d dqoe=%b want 0 0", fifo_count, sram_dq_oe); end
        bus.rd_addr = 17'h00200; bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h55) begin n_err++; $display("FAIL raw_data got v=%b d=%h want v=1 d=55", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_reset_mid_write();
        int cyc = 0;
        int base;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 17'h00900 + 17'(i); bus.wr_data = 8'h90 + 8'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        while (sram_n_we !== 1'b0 && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (sram_n_we !== 1'b0) begin n_err++; $display("FAIL rmw_write_start got n_we=%b want 0", sram_n_we); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (sram_n_we !== 1'b1)  begin n_err++; $display("FAIL rmw_n_we got %b want 1", sram_n_we); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL rmw_dq_oe got %b want 0", sram_dq_oe); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rmw_count got %0d want 0", fifo_count); end
        tick();
        reset = 1'b0;
        base = wcount;
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (wcount != base) begin n_err++; $display("FAIL rmw_no_writes got %0d want 0", wcount - base); end
        n_cmp++; if (sram_n_we !== 1'b1 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rmw_quiet got we=%b v=%b want 1 0", sram_n_we, bus.rd_valid); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 8'h00;
        test_reset();
        test_single_read();
        test_single_write();
        test_fill();
        test_collision();
        test_back_to_back();
        test_read_after_write();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
